// File: rtl/univ_shift_reg_pkg.sv
// Shared mode and FSM state encodings for univ_shift_reg.
package univ_shift_reg_pkg;
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_INC  = 3'd6;
    localparam logic [2:0] MODE_DEC  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/univ_shift_reg_ctl.sv
// Auto-serialiser control: IDLE -> SHIFT (N cycles) -> DONE (1 cycle) -> IDLE.
module univ_shift_reg_ctl
    import univ_shift_reg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic ck,
    input  logic rn,
    input  logic start,
    output logic idle,
    output logic shift_en,
    output logic busy,
    output logic done
);
    localparam int CW = $clog2(N);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                cnt_nxt  = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign idle = (state == ST_IDLE);
    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);
endmodule

// File: rtl/univ_shift_reg.sv
// N-bit universal register with built-in parallel-to-serial shifter.
// Define UNIV_SHIFT_REG_SAT_EN for saturating INC/DEC and the sat flag output.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         ck,
    input  logic         rn,
    input  logic [2:0]   mode,
    input  logic [N-1:0] inp,
    input  logic         sin,
    input  logic         start,
    output logic [N-1:0] out,
    output logic         sout,
    output logic         busy,
    output logic         done
`ifdef UNIV_SHIFT_REG_SAT_EN
    ,
    output logic         sat
`endif
);
    localparam logic [N-1:0] ONE = 1;

    logic         idle, shift_en;
    logic [N-1:0] out_nxt;

    univ_shift_reg_ctl #(.N(N)) u_ctl (
        .ck       (ck),
        .rn       (rn),
        .start    (start),
        .idle     (idle),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done)
    );

`ifdef UNIV_SHIFT_REG_SAT_EN
    logic sat_nxt;
`endif

    // Serialiser shift wins; mode only applies in IDLE when start is low.
    always_comb begin
        out_nxt = out;
`ifdef UNIV_SHIFT_REG_SAT_EN
        sat_nxt = 1'b0;
`endif
        if (shift_en) begin
            out_nxt = MSB_FIRST ? {out[N-2:0], sin} : {sin, out[N-1:1]};
        end else if (idle && !start) begin
            case (mode)
                MODE_HOLD: out_nxt = out;
                MODE_LOAD: out_nxt = inp;
                MODE_SHL:  out_nxt = {out[N-2:0], sin};
                MODE_SHR:  out_nxt = {sin, out[N-1:1]};
                MODE_ROL:  out_nxt = {out[N-2:0], out[N-1]};
                MODE_ROR:  out_nxt = {out[0], out[N-1:1]};
`ifdef UNIV_SHIFT_REG_SAT_EN
                MODE_INC:  if (&out) sat_nxt = 1'b1; else out_nxt = out + ONE;
                MODE_DEC:  if (~|out) sat_nxt = 1'b1; else out_nxt = out - ONE;
`else
                MODE_INC:  out_nxt = out + ONE;
                MODE_DEC:  out_nxt = out - ONE;
`endif
                default:   out_nxt = out;
            endcase
        end
    end

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) out <= '0;
        else     out <= out_nxt;
    end

`ifdef UNIV_SHIFT_REG_SAT_EN
    always_ff @(posedge ck or negedge rn) begin
        if (!rn) sat <= 1'b0;
        else     sat <= sat_nxt;
    end
`endif

    assign sout = MSB_FIRST ? out[N-1] : out[0];
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the team's plain load/hold register.
- N-bit universal register: hold, parallel load, shift left/right, rotate, increment and decrement.
- Built-in auto-serialiser: a start pulse shifts the whole word out on a serial pin, with busy/done status.
- Used as a general datapath holding register and as a parallel-to-serial front end for simple serial links.

Parameters:
- N, 4, register width in bits; legal range N >= 2.
- MSB_FIRST, 1, 1 = serialise MSB first (shift left); 0 = LSB first (shift right).

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- rn  input  1  reset, asynchronous, active-low.
- mode  input  3  operation select; sampled only in IDLE.
- inp  input  N  parallel load data.
- sin  input  1  serial fill bit for shift modes and auto-serialise.
- start  input  1  begin auto-serialise; sampled only in IDLE.
- out  output  N  register contents, driven directly from flops.
- sout  output  1  serial output: out[N-1] if MSB_FIRST, else out[0]; combinational from out.
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse in DONE state.

Behaviour:
- Reset (rn=0, async): out=0, state=IDLE, bit counter=0, busy=0, done=0.
- Reset takes effect immediately, including mid-serialise; no partial state survives.
- Mode encoding in IDLE, applied at the rising edge:
  - 0 HOLD: out unchanged.
  - 1 LOAD: out = inp.
  - 2 SHL: out = {out[N-2:0], sin}.
  - 3 SHR: out = {sin, out[N-1:1]}.
  - 4 ROL: out = {out[N-2:0], out[N-1]}.
  - 5 ROR: out = {out[0], out[N-1:1]}.
  - 6 INC: out = out+1, modulo 2^N.
  - 7 DEC: out = out-1, modulo 2^N.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> SHIFT, counter=0, out unchanged on that edge.
  - start has priority over mode in the same cycle; mode is ignored.
  - start=0 -> apply mode.
- SHIFT:
  - busy=1.
  - During SHIFT cycle i (i = 0..N-1), sout presents serial bit i.
  - At each edge, out shifts toward sout, filling with sin: SHL if MSB_FIRST, SHR otherwise. Counter increments.
  - At the edge where counter == N-1 -> DONE.
  - SHIFT lasts exactly N cycles.
  - mode and start are ignored; start asserted during busy is dropped, not queued.
- DONE:
  - done=1, busy=0, out held.
  - Next edge -> IDLE unconditionally.
  - start during DONE is ignored.
- Latency: start sampled at edge E0 -> busy high from E0 to E0+N -> done high for one cycle -> IDLE at E0+N+1.
- Counter width is $clog2(N); wrap is unreachable.

Optional Feature:
- UNIV_SHIFT_REG_SAT_EN defined:
  - INC at all-ones holds all-ones; DEC at zero holds zero.
  - Extra output sat (1 bit, registered) is high for the cycle after a clamped INC/DEC, otherwise 0; reset value 0.
- Not defined: INC/DEC wrap modulo 2^N and the sat port does not exist.

Decomposition:
- Package univ_shift_reg_pkg holds:
  - mode localparams MODE_HOLD..MODE_DEC (3-bit);
  - state encoding ST_IDLE/ST_SHIFT/ST_DONE (2-bit).
- One sub-module, univ_shift_reg_ctl: the FSM plus bit counter. It takes start and produces busy, done and a shift-enable.
- The datapath mux and register stay in the top module.

Test Plan:
- N=4: rn low mid-operation with out=4'hA and busy=1 -> out=0, busy=0, done=0 immediately without a clock edge; IDLE after release.
- N=4: LOAD 4'b1011, then ROL -> 4'b0111, then ROR -> 4'b1011; then SHR with sin=1 -> 4'b1101; then SHL with sin=0 -> 4'b1010.
- N=4, MSB_FIRST=1: LOAD 4'b1011, start=1 with mode=LOAD and inp=0 in the same cycle, sin=0:
  - out still 1011 after the start edge;
  - sout = 1,0,1,1 over 4 busy cycles;
  - done one cycle after, then out=4'b0000.
- N=4, MSB_FIRST=0: LOAD 4'b0110, serialise with sin=1 -> sout = 0,1,1,0; final out=4'b1111.
- During busy: pulse start and set mode=INC -> no extra serialise cycle, no increment; busy stays exactly 4 cycles.
- INC from 4'hF -> 4'h0 and DEC from 4'h0 -> 4'hF. With UNIV_SHIFT_REG_SAT_EN: both hold the value, and sat=1 for one cycle.
